// File: rtl/riscv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit beside the Execute-stage ALU.
// Multiply: shift-add, STEPS bits per CALC cycle. Divide: restoring division.
// The divider is built only when RISCV_MULDIV_DIV_EN is defined. Otherwise
// funct3[2]=1 operations finish on the fast path with a zero result.
//
// state | meaning
// IDLE  | waiting for an M instruction in Execute
// CALC  | retiring STEPS product/quotient bits per cycle
// FIX   | sign correction and result selection
// DONE  | result valid, DoneE strobe
module riscv_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  localparam int CNT_W = $clog2(XLEN / STEPS + 1);
  localparam logic [CNT_W-1:0] N_CYC = CNT_W'(XLEN / STEPS);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct_q, funct_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  // Multiply: {high accumulator, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sign_a, sign_b, a_neg, b_neg, neg_start;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              fast_take;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN-1:0]   fix_res;

  // Operand signedness, absolute values and the fast-path decision at start.
  always_comb begin
    if (!FunctE[2]) begin
      sign_a = (FunctE[1:0] == 2'b01) || (FunctE[1:0] == 2'b10);
      sign_b = (FunctE[1:0] == 2'b01);
    end else begin
      sign_a = ~FunctE[0];
      sign_b = ~FunctE[0];
    end
    a_neg     = sign_a & SrcAE[XLEN-1];
    b_neg     = sign_b & SrcBE[XLEN-1];
    abs_a     = a_neg ? -SrcAE : SrcAE;
    abs_b     = b_neg ? -SrcBE : SrcBE;
    // Remainder takes the dividend's sign; everything else the product sign.
    neg_start = (FunctE[2] && FunctE[1]) ? a_neg : (a_neg ^ b_neg);
    fast_take = 1'b0;
    fast_res  = '0;
`ifdef RISCV_MULDIV_DIV_EN
    if (FunctE[2]) begin
      if (SrcBE == '0) begin
        fast_take = 1'b1;
        fast_res  = FunctE[1] ? SrcAE : '1;
      end else if (!FunctE[0] && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcBE)) begin
        fast_take = 1'b1;
        fast_res  = FunctE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
    end
`else
    fast_take = FunctE[2];
`endif
  end

  // One CALC cycle: STEPS iterations of shift-add or restoring division.
  always_comb begin
    logic [XLEN:0] sum;
`ifdef RISCV_MULDIV_DIV_EN
    logic [XLEN:0] rs;
    logic [XLEN:0] diff;
    rs   = '0;
    diff = '0;
`endif
    sum       = '0;
    prod_step = prod_q;
    for (int i = 0; i < STEPS; i++) begin
`ifdef RISCV_MULDIV_DIV_EN
      if (funct_q[2]) begin
        rs   = {prod_step[2*XLEN-1:XLEN], prod_step[XLEN-1]};
        diff = rs - {1'b0, b_q};
        if (!diff[XLEN])
          prod_step = {diff[XLEN-1:0], prod_step[XLEN-2:0], 1'b1};
        else
          prod_step = {rs[XLEN-1:0], prod_step[XLEN-2:0], 1'b0};
      end else
`endif
      begin
        sum       = {1'b0, prod_step[2*XLEN-1:XLEN]} + (prod_step[0] ? {1'b0, a_q} : '0);
        prod_step = {sum, prod_step[XLEN-1:1]};
      end
    end
  end

  // Sign correction and result selection used in FIX.
  always_comb begin
    logic [2*XLEN-1:0] full;
    full    = neg_q ? -prod_q : prod_q;
    fix_res = '0;
    if (!funct_q[2]) begin
      fix_res = (funct_q[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end else begin
`ifdef RISCV_MULDIV_DIV_EN
      if (funct_q[1])
        fix_res = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
      else
        fix_res = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
`endif
    end
  end

  // Next-state, datapath loads and the Busy/Done outputs.
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    BusyE    = 1'b0;
    DoneE    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE && !FlushE) begin
          BusyE   = 1'b1;
          funct_d = FunctE;
          neg_d   = neg_start;
          a_d     = abs_a;
          b_d     = abs_b;
          prod_d  = FunctE[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
          cnt_d   = N_CYC;
          if (fast_take) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        BusyE = 1'b1;
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          prod_d = prod_step;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        BusyE = 1'b1;
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // A flush in this cycle kills the finishing instruction, so no strobe.
        DoneE   = ~FlushE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ResultE = result_q;

endmodule

// File: doc/riscv_muldiv_iter.md
# riscv_muldiv_iter

Iterative RV32M multiply/divide unit for the pipelined RISC-V core, sitting beside the Execute-stage ALU. It is parametrised in data width and bits retired per cycle. It raises a stall request to the hazard unit while an operation is in flight, and pulses a done strobe when the result is ready to be written back. Killed operations from an Execute flush are discarded without a result.

## Interface
- XLEN, 32: operand/result width; even, ≥ 8.
- STEPS, 1: quotient/product bits retired per CALC cycle; must divide XLEN (1, 2 or 4).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns unit to IDLE.
- StartE  in  1  M-extension instruction present in Execute; held high by the pipeline while stalled.
- FunctE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  XLEN  rs1 operand (multiplicand/dividend), post-forwarding.
- SrcBE  in  XLEN  rs2 operand (multiplier/divisor), post-forwarding.
- FlushE  in  1  kill current operation.
- BusyE  out  1  stall request to hazard unit (StallF/StallD, hold E).
- DoneE  out  1  one-cycle result-valid strobe.
- ResultE  out  XLEN  result; valid when DoneE=1, held until next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset → IDLE, BusyE=0, DoneE=0, ResultE=0, all internal registers 0.
- IDLE, StartE=1, FlushE=0: capture FunctE, signs, and absolute values of operands (signedness per funct3; MULHSU treats SrcBE unsigned). Load counter with XLEN/STEPS.
  - Fast path → DONE: divisor zero (DIV/DIVU quotient = all ones; REM/REMU = SrcAE); signed overflow, SrcAE = most-negative and SrcBE = −1 (DIV = most-negative; REM = 0).
  - Otherwise → CALC.
- CALC: multiply is shift-add into a 2·XLEN product; divide is restoring division. Each cycle retires STEPS bits and decrements the counter. Counter reaching 0 → FIX.
- FIX: apply sign correction (two's-complement negate of product, quotient or remainder as required). Select the result: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*. Register into ResultE. → DONE.
- DONE: DoneE=1, BusyE=0; the instruction leaves Execute at the end of this cycle. StartE is ignored in DONE, because it still belongs to the finishing instruction. → IDLE.
- FlushE=1 in any state: next state IDLE, no DoneE, ResultE unchanged. FlushE has priority over StartE.
- StartE in CALC/FIX is ignored (same stalled instruction). Operand changes after capture have no effect.
- Remainder sign follows the dividend; quotient is truncated toward zero.

## Timing
- BusyE = (IDLE & StartE & ~FlushE) | CALC | FIX. It is combinational so the hazard unit stalls in the start cycle.
- Start accepted in cycle t, normal path: CALC t+1 … t+N with N = XLEN/STEPS; FIX t+N+1; DoneE at t+N+2. XLEN=32, STEPS=1: DoneE at t+34.
- Fast path: DONE at t+1; DoneE at t+1.
- After DONE, IDLE at t+N+3. A following M instruction, arriving in Execute that cycle, is accepted there.
- Reset asserted mid-operation: IDLE next edge; no DoneE produced.

## Configuration
- RISCV_MULDIV_DIV_EN defined: all eight funct3 operations supported as above.
- Undefined: divider datapath and remainder registers are omitted. Funct3[2]=1 operations take the fast path and return ResultE=0 with DoneE at t+1. Multiply behaviour and timing are unchanged.

## Test plan
- Reset then MUL, SrcAE=7, SrcBE=0xFFFFFFFD (XLEN=32, STEPS=1) → BusyE high t…t+33; DoneE only at t+34; ResultE=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIVU 100/7 → 14 and REMU → 2. DIV −7/2 → 0xFFFFFFFD and REM → 0xFFFFFFFF. All with DoneE at t+34.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All with DoneE at t+1.
- FlushE at t+10 of a MUL → BusyE=0 at t+11; no DoneE; ResultE keeps its prior value. A new DIVU 9/3 started at t+11 → 3 at t+45.
- Reset at t+5 mid-DIV → IDLE, outputs 0, no DoneE. With STEPS=4, MUL 3×5 → 15 with DoneE at t+10. Macro undefined: DIVU 9/3 → 0 at t+1.
